// File: rtl/debounce_bank.sv
// debounce_bank: per-channel 2-FF synchroniser, debounce filter (leading- or
// trailing-edge) and edge detector, with a shared tick prescaler and a sticky
// per-channel event register that a CPU can poll and clear.
module debounce_bank #(
    parameter int                  CHANNELS = 4,
    parameter int                  PRESCALE = 1000,
    parameter int                  DELAY    = 1500,
    parameter string               MODE     = "LEADING",
    parameter logic [CHANNELS-1:0] INIT     = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in_data,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change,
    output logic [CHANNELS-1:0] ev_pending,
    input  logic [CHANNELS-1:0] ev_clr
);

    localparam int          PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int          CW        = $clog2(DELAY + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] DELAY_C   = CW'(DELAY);
    localparam bit          TRAILING  = (MODE == "TRAILING");

    logic [PW-1:0]       presc_q, presc_d;
    logic                tick_s;
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] s_q;
    logic [CHANNELS-1:0] prev_q, prev_d;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CHANNELS-1:0] ev_q, ev_d;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];

    // Shared prescaler: counts 0..PRESCALE-1 and flags the last count as a tick.
    // With PRESCALE=1 the counter is pinned at 0, so tick is permanently high.
    always_comb begin
        tick_s  = 1'b0;
        presc_d = presc_q + PW'(1);
        if (presc_q == PRESC_MAX) begin
            tick_s  = 1'b1;
            presc_d = {PW{1'b0}};
        end else begin
            tick_s  = 1'b0;
        end
    end

    // Per-channel debounce filter: decides the next level, lockout/stability
    // counter and the one-cycle edge pulses that accompany a level change.
    always_comb begin
        prev_d  = s_q;
        level_d = level_q;
        rise_d  = {CHANNELS{1'b0}};
        fall_d  = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (TRAILING) begin
                // Any movement restarts the stability window.
                if (s_q[i] != prev_q[i]) begin
                    cnt_d[i] = DELAY_C;
                end else if ((cnt_q[i] != {CW{1'b0}}) && tick_s) begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end else if ((cnt_q[i] == {CW{1'b0}}) && (s_q[i] != level_q[i])) begin
                    level_d[i] = s_q[i];
                    rise_d[i]  = s_q[i];
                    fall_d[i]  = ~s_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
            end else begin
                // Accept immediately, then ignore the pin until the lockout expires.
                if ((cnt_q[i] == {CW{1'b0}}) && (s_q[i] != level_q[i])) begin
                    level_d[i] = s_q[i];
                    rise_d[i]  = s_q[i];
                    fall_d[i]  = ~s_q[i];
                    cnt_d[i]   = DELAY_C;
                end else if ((cnt_q[i] != {CW{1'b0}}) && tick_s) begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
            end
        end
    end

    // Sticky event flags: a pulse in the current cycle beats a simultaneous clear.
    always_comb begin
        ev_d = (ev_q & ~ev_clr) | rise_q | fall_q;
    end

    // State registers with synchronous reset; synchronisers and level restart at INIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= {PW{1'b0}};
            sync1_q <= INIT;
            s_q     <= INIT;
            prev_q  <= INIT;
            level_q <= INIT;
            rise_q  <= {CHANNELS{1'b0}};
            fall_q  <= {CHANNELS{1'b0}};
            ev_q    <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= {CW{1'b0}};
            end
        end else begin
            presc_q <= presc_d;
            sync1_q <= in_data;
            s_q     <= sync1_q;
            prev_q  <= prev_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            ev_q    <= ev_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level      = level_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign ev_pending = ev_q;
    assign any_change = |(rise_q | fall_q);

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: four instances (leading, trailing, prescaled leading,
// INIT=1) exercised by directed scenarios and randomized bouncing inputs that are
// scored against window/lockout rules expressed on the pin history.
module tb_debounce_bank;

    localparam int D4     = 4;
    localparam int RAND_N = 300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int p_rst_edge = 0;

    // Leading, PRESCALE=1, DELAY=4
    logic       l_rst;
    logic [1:0] l_in, l_lvl, l_rise, l_fall, l_ev, l_clr;
    logic       l_any;
    // Trailing, PRESCALE=1, DELAY=4
    logic       t_rst;
    logic [1:0] t_in, t_lvl, t_rise, t_fall, t_ev, t_clr;
    logic       t_any;
    // Leading, PRESCALE=5, DELAY=2, one channel
    logic       p_rst;
    logic [0:0] p_in, p_lvl, p_rise, p_fall, p_ev, p_clr;
    logic       p_any;
    // Leading, INIT=2'b11
    logic       i_rst;
    logic [1:0] i_in, i_lvl, i_rise, i_fall, i_ev, i_clr;
    logic       i_any;

    debounce_bank #(.CHANNELS(2), .PRESCALE(1), .DELAY(D4), .MODE("LEADING"), .INIT(2'b00)) u_lead (
        .clk(clk), .reset(l_rst), .in_data(l_in), .level(l_lvl), .rise(l_rise), .fall(l_fall),
        .any_change(l_any), .ev_pending(l_ev), .ev_clr(l_clr));

    debounce_bank #(.CHANNELS(2), .PRESCALE(1), .DELAY(D4), .MODE("TRAILING"), .INIT(2'b00)) u_trail (
        .clk(clk), .reset(t_rst), .in_data(t_in), .level(t_lvl), .rise(t_rise), .fall(t_fall),
        .any_change(t_any), .ev_pending(t_ev), .ev_clr(t_clr));

    debounce_bank #(.CHANNELS(1), .PRESCALE(5), .DELAY(2), .MODE("LEADING"), .INIT(1'b0)) u_pre (
        .clk(clk), .reset(p_rst), .in_data(p_in), .level(p_lvl), .rise(p_rise), .fall(p_fall),
        .any_change(p_any), .ev_pending(p_ev), .ev_clr(p_clr));

    debounce_bank #(.CHANNELS(2), .PRESCALE(1), .DELAY(D4), .MODE("LEADING"), .INIT(2'b11)) u_init1 (
        .clk(clk), .reset(i_rst), .in_data(i_in), .level(i_lvl), .rise(i_rise), .fall(i_fall),
        .any_change(i_any), .ev_pending(i_ev), .ev_clr(i_clr));

    task automatic cycle();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        l_rst = 1'b1; t_rst = 1'b1; p_rst = 1'b1; i_rst = 1'b1;
        l_in = 2'b00; t_in = 2'b00; p_in = 1'b0; i_in = 2'b11;
        l_clr = 2'b00; t_clr = 2'b00; p_clr = 1'b0; i_clr = 2'b00;
        repeat (3) cycle();
        checks++;
        if ({l_lvl, l_rise, l_fall, l_any, l_ev} !== 9'b0) begin
            failures++; $display("FAIL reset_lead got=%b exp=%b", {l_lvl, l_rise, l_fall, l_any, l_ev}, 9'b0);
        end
        checks++;
        if ({t_lvl, t_rise, t_fall, t_any, t_ev} !== 9'b0) begin
            failures++; $display("FAIL reset_trail got=%b exp=%b", {t_lvl, t_rise, t_fall, t_any, t_ev}, 9'b0);
        end
        checks++;
        if ({p_lvl, p_rise, p_fall, p_any, p_ev} !== 5'b0) begin
            failures++; $display("FAIL reset_pre got=%b exp=%b", {p_lvl, p_rise, p_fall, p_any, p_ev}, 5'b0);
        end
        checks++;
        if ({i_lvl, i_rise, i_fall, i_any, i_ev} !== 9'b11_00_00_0_00) begin
            failures++; $display("FAIL reset_init1 got=%b exp=%b", {i_lvl, i_rise, i_fall, i_any, i_ev}, 9'b11_00_00_0_00);
        end
        l_rst = 1'b0; t_rst = 1'b0; p_rst = 1'b0; i_rst = 1'b0;
        p_rst_edge = cyc;
        cycle();
        checks++;
        if ({l_rise, l_fall, l_any, i_rise, i_fall, i_any, i_lvl} !== 12'b00_00_0_00_00_0_11) begin
            failures++; $display("FAIL reset_first_cycle got=%b exp=%b",
                {l_rise, l_fall, l_any, i_rise, i_fall, i_any, i_lvl}, 12'b00_00_0_00_00_0_11);
        end
    endtask

    task automatic test_lead_basic();
        logic [6:0] exp;
        l_in = 2'b00;
        repeat (8) cycle();
        l_in = 2'b01;
        for (int j = 1; j <= 4; j++) begin
            cycle();
            if (j < 3)       exp = 7'b00_00_00_0;
            else if (j == 3) exp = 7'b01_01_00_1;
            else             exp = 7'b01_00_00_0;
            checks++;
            if ({l_lvl, l_rise, l_fall, l_any} !== exp) begin
                failures++; $display("FAIL lead_accept j=%0d got=%b exp=%b", j, {l_lvl, l_rise, l_fall, l_any}, exp);
            end
        end
        checks++;
        if (l_ev !== 2'b01) begin
            failures++; $display("FAIL lead_ev_set got=%b exp=%b", l_ev, 2'b01);
        end
        // bounce inside the lockout, then a steady low
        l_in = 2'b00;
        for (int j = 5; j <= 13; j++) begin
            cycle();
            exp = (j == 13) ? 7'b00_00_01_1 : 7'b01_00_00_0;
            checks++;
            if ({l_lvl, l_rise, l_fall, l_any} !== exp) begin
                failures++; $display("FAIL lead_bounce j=%0d got=%b exp=%b", j, {l_lvl, l_rise, l_fall, l_any}, exp);
            end
            if (j == 5)  l_in = 2'b01;
            if (j == 10) l_in = 2'b00;
        end
    endtask

    task automatic test_events();
        repeat (8) cycle();
        l_in = 2'b10;
        repeat (3) cycle();
        checks++;
        if ({l_lvl, l_rise, l_ev} !== 6'b10_10_01) begin
            failures++; $display("FAIL ev_rise1 got=%b exp=%b", {l_lvl, l_rise, l_ev}, 6'b10_10_01);
        end
        l_clr = 2'b10;
        cycle();
        checks++;
        if (l_ev !== 2'b11) begin
            failures++; $display("FAIL ev_set_wins got=%b exp=%b", l_ev, 2'b11);
        end
        l_clr = 2'b00;
        cycle();
        checks++;
        if (l_ev !== 2'b11) begin
            failures++; $display("FAIL ev_sticky got=%b exp=%b", l_ev, 2'b11);
        end
        l_clr = 2'b10;
        cycle();
        checks++;
        if (l_ev !== 2'b01) begin
            failures++; $display("FAIL ev_clear got=%b exp=%b", l_ev, 2'b01);
        end
        cycle();
        checks++;
        if (l_ev !== 2'b01) begin
            failures++; $display("FAIL ev_clear_noop got=%b exp=%b", l_ev, 2'b01);
        end
        l_clr = 2'b00;
    endtask

    task automatic test_trail();
        logic [6:0] exp;
        t_in = 2'b00;
        repeat (20) cycle();
        t_in = 2'b01;
        repeat (3) cycle();
        t_in = 2'b00;
        for (int j = 0; j < 14; j++) begin
            cycle();
            checks++;
            if ({t_lvl, t_rise, t_fall, t_any} !== 7'b0) begin
                failures++; $display("FAIL trail_glitch j=%0d got=%b exp=%b", j, {t_lvl, t_rise, t_fall, t_any}, 7'b0);
            end
        end
        t_in = 2'b01;
        for (int j = 1; j <= 8; j++) begin
            cycle();
            exp = (j == 8) ? 7'b01_01_00_1 : 7'b00_00_00_0;
            checks++;
            if ({t_lvl, t_rise, t_fall, t_any} !== exp) begin
                failures++; $display("FAIL trail_rise j=%0d got=%b exp=%b", j, {t_lvl, t_rise, t_fall, t_any}, exp);
            end
        end
        t_in = 2'b00;
        for (int j = 1; j <= 8; j++) begin
            cycle();
            exp = (j == 8) ? 7'b00_00_01_1 : 7'b01_00_00_0;
            checks++;
            if ({t_lvl, t_rise, t_fall, t_any} !== exp) begin
                failures++; $display("FAIL trail_fall j=%0d got=%b exp=%b", j, {t_lvl, t_rise, t_fall, t_any}, exp);
            end
        end
        t_in = 2'b01;
        for (int j = 1; j <= 14; j++) begin
            cycle();
            exp = (j == 14) ? 7'b01_01_00_1 : 7'b00_00_00_0;
            checks++;
            if ({t_lvl, t_rise, t_fall, t_any} !== exp) begin
                failures++; $display("FAIL trail_restart j=%0d got=%b exp=%b", j, {t_lvl, t_rise, t_fall, t_any}, exp);
            end
            if (j == 5) t_in = 2'b00;
            if (j == 6) t_in = 2'b01;
        end
    endtask

    task automatic test_prescaler();
        logic plev;
        int a, j, exp_edge, got_edge;
        plev = 1'b0;
        for (int t = 0; t < 4; t++) begin
            repeat (12 + $urandom_range(0, 6)) cycle();
            p_in = ~plev;
            repeat (3) cycle();
            checks++;
            if ({p_lvl, p_rise, p_fall} !== {~plev, ~plev, plev}) begin
                failures++; $display("FAIL pre_accept t=%0d got=%b exp=%b", t, {p_lvl, p_rise, p_fall}, {~plev, ~plev, plev});
            end
            plev = ~plev;
            a = cyc;
            p_in = ~plev;
            // ticks land on edges a multiple of 5 after the last reset edge;
            // two ticks drain the lockout, the next edge accepts the opposite level
            j = 1;
            while (((a + j - p_rst_edge) % 5) != 0) j++;
            exp_edge = a + j + 6;
            got_edge = -1;
            for (int w = 0; w < 20 && got_edge < 0; w++) begin
                cycle();
                if (p_lvl !== plev) got_edge = cyc;
            end
            checks++;
            if (got_edge != exp_edge) begin
                failures++; $display("FAIL pre_opposite_edge t=%0d got=%0d exp=%0d", t, got_edge, exp_edge);
            end
            checks++;
            if ((got_edge - a - 1) < 6 || (got_edge - a - 1) > 10) begin
                failures++; $display("FAIL pre_lockout_len t=%0d got=%0d exp=6..10", t, got_edge - a - 1);
            end
            plev = ~plev;
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] exp;
        l_in = 2'b11;
        repeat (3) cycle();
        checks++;
        if ({l_lvl, l_rise} !== 4'b11_01) begin
            failures++; $display("FAIL rstmid_pre got=%b exp=%b", {l_lvl, l_rise}, 4'b11_01);
        end
        l_rst = 1'b1;
        for (int j = 0; j < 2; j++) begin
            cycle();
            checks++;
            if ({l_lvl, l_rise, l_fall, l_any, l_ev} !== 9'b0) begin
                failures++; $display("FAIL rstmid_during j=%0d got=%b exp=%b", j, {l_lvl, l_rise, l_fall, l_any, l_ev}, 9'b0);
            end
        end
        l_rst = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            cycle();
            exp = (j == 3) ? 7'b11_11_00_1 : 7'b0;
            checks++;
            if ({l_lvl, l_rise, l_fall, l_any} !== exp) begin
                failures++; $display("FAIL rstmid_after j=%0d got=%b exp=%b", j, {l_lvl, l_rise, l_fall, l_any}, exp);
            end
        end
    endtask

    task automatic test_init_high();
        i_in = 2'b11;
        i_rst = 1'b1;
        repeat (2) cycle();
        checks++;
        if ({i_lvl, i_rise, i_fall, i_ev} !== 8'b11_00_00_00) begin
            failures++; $display("FAIL init1_during got=%b exp=%b", {i_lvl, i_rise, i_fall, i_ev}, 8'b11_00_00_00);
        end
        i_rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            cycle();
            checks++;
            if ({i_lvl, i_rise, i_fall, i_any} !== 7'b11_00_00_0) begin
                failures++; $display("FAIL init1_after j=%0d got=%b exp=%b", j, {i_lvl, i_rise, i_fall, i_any}, 7'b11_00_00_0);
            end
        end
    endtask

    // Leading model: a differing synchronised sample is taken once more than
    // DELAY edges have passed since the previous acceptance.
    task automatic test_lead_random();
        logic [1:0] pins [RAND_N];
        logic [1:0] mlev, mrise, mfall, mev, pprev, clr, cur;
        int last_acc [2];
        logic sv;
        l_in = 2'b00; l_clr = 2'b00;
        repeat (20) cycle();
        l_clr = 2'b11; cycle(); l_clr = 2'b00;
        mlev = 2'b00; mev = 2'b00; pprev = 2'b00; cur = 2'b00;
        last_acc[0] = -100; last_acc[1] = -100;
        for (int k = 0; k < RAND_N; k++) begin
            for (int c = 0; c < 2; c++) if ($urandom_range(0, 3) == 0) cur[c] = ~cur[c];
            pins[k] = cur;
            clr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            l_in = cur; l_clr = clr;
            cycle();
            mrise = 2'b00; mfall = 2'b00;
            for (int c = 0; c < 2; c++) begin
                sv = 1'b0;
                if (k >= 2) sv = pins[k-2][c];
                if ((k - last_acc[c]) > D4 && sv !== mlev[c]) begin
                    mlev[c] = sv;
                    if (sv) mrise[c] = 1'b1; else mfall[c] = 1'b1;
                    last_acc[c] = k;
                end
            end
            mev = (mev & ~clr) | pprev;
            pprev = mrise | mfall;
            checks++;
            if ({l_lvl, l_rise, l_fall, l_any, l_ev} !== {mlev, mrise, mfall, |(mrise | mfall), mev}) begin
                failures++; $display("FAIL lead_rand k=%0d got=%b exp=%b", k,
                    {l_lvl, l_rise, l_fall, l_any, l_ev}, {mlev, mrise, mfall, |(mrise | mfall), mev});
            end
        end
        l_clr = 2'b00;
    endtask

    // Trailing model: the level follows the synchronised input once it has held
    // one value over the last DELAY+2 synchronised samples.
    task automatic test_trail_random();
        logic [1:0] pins [RAND_N];
        logic [1:0] mlev, mrise, mfall, mev, pprev, clr, cur;
        logic sv, sj;
        bit stable;
        t_in = 2'b00; t_clr = 2'b00;
        repeat (20) cycle();
        t_clr = 2'b11; cycle(); t_clr = 2'b00;
        mlev = 2'b00; mev = 2'b00; pprev = 2'b00; cur = 2'b00;
        for (int k = 0; k < RAND_N; k++) begin
            for (int c = 0; c < 2; c++) if ($urandom_range(0, 7) == 0) cur[c] = ~cur[c];
            pins[k] = cur;
            clr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            t_in = cur; t_clr = clr;
            cycle();
            mrise = 2'b00; mfall = 2'b00;
            for (int c = 0; c < 2; c++) begin
                sv = 1'b0;
                if (k >= 2) sv = pins[k-2][c];
                stable = 1'b1;
                for (int j = k - 2 - D4; j <= k - 1; j++) begin
                    sj = 1'b0;
                    if (j - 1 >= 0) sj = pins[j-1][c];
                    if (sj !== sv) stable = 1'b0;
                end
                if (stable && sv !== mlev[c]) begin
                    mlev[c] = sv;
                    if (sv) mrise[c] = 1'b1; else mfall[c] = 1'b1;
                end
            end
            mev = (mev & ~clr) | pprev;
            pprev = mrise | mfall;
            checks++;
            if ({t_lvl, t_rise, t_fall, t_any, t_ev} !== {mlev, mrise, mfall, |(mrise | mfall), mev}) begin
                failures++; $display("FAIL trail_rand k=%0d got=%b exp=%b", k,
                    {t_lvl, t_rise, t_fall, t_any, t_ev}, {mlev, mrise, mfall, |(mrise | mfall), mev});
            end
        end
        t_clr = 2'b00;
    endtask

    initial begin
        test_reset();
        test_lead_basic();
        test_events();
        test_trail();
        test_prescaler();
        test_reset_mid();
        test_init_high();
        test_lead_random();
        test_trail_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised multi-channel debouncer for pushbuttons, limit switches and encoder contacts.
- Each channel has its own 2-FF synchroniser, debounce filter and edge detector.
- Emits a debounced level, a one-cycle rise pulse and a one-cycle fall pulse per channel, plus a sticky per-channel event register with a clear input for polled CPU access.
- One prescaler is shared by all channels so long debounce times stay small.

Parameters:
- CHANNELS, 4, number of independent inputs (1..32).
- PRESCALE, 1000, clk cycles per debounce tick (>=1); PRESCALE=1 means every cycle is a tick.
- DELAY, 1500, debounce length in ticks (1..65535).
- MODE, "LEADING", "LEADING" = accept an edge immediately, then ignore the input for DELAY ticks; "TRAILING" = accept a level only after it has been stable for DELAY ticks.
- INIT, {CHANNELS{1'b0}}, reset value of the synchronisers and of `level`, per channel.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  CHANNELS  raw asynchronous inputs.
- level  out  CHANNELS  debounced level.
- rise  out  CHANNELS  one-cycle pulse, debounced 0->1.
- fall  out  CHANNELS  one-cycle pulse, debounced 1->0.
- any_change  out  1  OR of (rise | fall).
- ev_pending  out  CHANNELS  sticky per-channel edge flags.
- ev_clr  in  CHANNELS  clear mask for ev_pending, applied on the clock edge.

Behaviour:
- Clock and reset:
  - One clock, `clk`. Reset is synchronous and active-high.
  - While `reset` is high: synchronisers := INIT, level := INIT, rise/fall := 0, ev_pending := 0, all channel counters := 0, prescaler := 0.
  - No edges are reported on the first cycle after reset.
- Synchroniser: two flops per channel. `s` is the second-stage output; a pin change is visible in `s` 2 clk later.
- Prescaler:
  - Free-running counter 0..PRESCALE-1.
  - `tick` is high in the cycle the counter equals PRESCALE-1; the counter then wraps to 0.
  - PRESCALE=1 gives tick constantly high.
  - Width is clog2(PRESCALE), minimum 1.
- Channel counter: width clog2(DELAY+1); saturates at 0 and never wraps below 0.
- LEADING mode, per channel:
  - If cnt==0 and s!=level: level<=s, cnt<=DELAY, and rise or fall asserts in the same cycle that level first shows the new value.
  - Else if cnt!=0 and tick: cnt<=cnt-1.
  - Input changes while cnt!=0 are ignored. If s still differs from level when cnt reaches 0, it is accepted on the next cycle.
  - Latency pin->level is 3 clk.
  - Lockout length is between (DELAY-1)*PRESCALE+1 and DELAY*PRESCALE clk.
- TRAILING mode, per channel:
  - Register `prev`<=s every cycle.
  - If s!=prev: cnt<=DELAY.
  - Else if cnt!=0 and tick: cnt<=cnt-1.
  - Else if cnt==0 and s!=level: level<=s with a rise/fall pulse.
  - Any glitch restarts the count. A pulse shorter than the stability time never changes level.
  - With PRESCALE=1, latency pin->level is 2+1+DELAY+1 = DELAY+4 clk.
- rise/fall:
  - Registered, exactly one clk wide.
  - Never both high on one channel.
  - Deasserted in reset.
- any_change: combinational OR of all rise and fall bits.
- ev_pending:
  - ev_pending[i] <= (ev_pending[i] & ~ev_clr[i]) | rise[i] | fall[i].
  - Uses the rise/fall of the current cycle, so the flag appears 1 clk after the pulse.
  - Simultaneous set and clear: set wins.
  - ev_clr on a bit that is already clear is a no-op.
- Channels are fully independent apart from the shared tick. Simultaneous edges on several channels are all reported in the same cycle.
- Reset mid-lockout or mid-count: the counter is discarded. If the pin differs from INIT after reset release, LEADING reports it after the 2-cycle synchroniser delay plus 1 clk.

Test Plan:
- LEADING, CHANNELS=2, PRESCALE=1, DELAY=4, INIT=0:
  - Stimulus: ch0 rises at cycle 10.
  - Required: level[0]=1 and rise[0]=1 at cycle 13 only; any_change=1 at cycle 13; ev_pending[0]=1 from cycle 14.
- LEADING bounce:
  - Stimulus: ch0 1->0->1 toggles at cycles 14, 15, 16 after an accepted rise at 13.
  - Required: level stays 1 and there are no fall pulses.
  - Stimulus: a steady 0 from cycle 20.
  - Required: fall[0] at cycle 23.
- TRAILING, PRESCALE=1, DELAY=4:
  - Stimulus: 3-cycle high glitch.
  - Required: no level change.
  - Stimulus: steady high from cycle 30.
  - Required: level=1 and rise=1 at cycle 34+DELAY... i.e. cycle 38.
  - Stimulus: a glitch at cycle 35.
  - Required: the count restarts.
- Prescaler, PRESCALE=5, DELAY=2, LEADING:
  - Required: the lockout after an accepted edge lasts between 6 and 10 clk, checked by the earliest accepted opposite edge.
- Event handshake:
  - Stimulus: ev_clr[1] asserted in the same cycle as rise[1].
  - Required: ev_pending[1]=1 afterwards.
  - Stimulus: ev_clr[1] alone.
  - Required: ev_pending[1] clears next cycle; ev_pending[0] is unaffected.
- Reset:
  - Stimulus: reset during LEADING lockout with the pin held at 1 and INIT=0.
  - Required: during reset level=0 and rise/fall/ev_pending=0; rise 3 clk after reset deasserts.
  - Stimulus: INIT=1 with the pin held at 1.
  - Required: no pulse after reset.
